// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, instruction register, control-flow resolution
// and the hardware return stack for the 14-bit MCU core.
module inst_fetch_unit #(
  parameter int          STACK_DEPTH  = 8,
  parameter logic [10:0] RESET_VECTOR = 11'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] Rom_addr_out,
  input  logic [13:0] Rom_data_in,
  input  logic        stall,
  input  logic        skip_req,
  output logic [13:0] ir_out,
  output logic        ir_valid,
  output logic [10:0] ir_pc,
  output logic        stk_ovf,
  output logic        stk_unf
);

  localparam int SPW = $clog2(STACK_DEPTH);
  localparam int DW  = SPW + 1;

  logic [10:0]    pc;
  logic [10:0]    pc_nxt;
  logic [SPW-1:0] sp;
  logic [DW-1:0]  depth;
  logic [10:0]    mem [STACK_DEPTH];

  logic is_goto;
  logic is_call;
  logic is_ret;
  logic do_jmp;
  logic do_push;
  logic do_pop;
  logic do_skip;
  logic bubble;
  logic full;
  logic empty;
  logic [10:0] pop_addr;

  assign Rom_addr_out = pc;

  assign is_goto = ir_valid && (ir_out[13:11] == 3'b101);
  assign is_call = ir_valid && (ir_out[13:11] == 3'b100);
  assign is_ret  = ir_valid && ((ir_out == 14'h0008)
                             || (ir_out == 14'h0009)
                             || (ir_out[13:10] == 4'b1101));

  assign do_jmp  = !stall && (is_goto || is_call);
  assign do_push = !stall && is_call;
  assign do_pop  = !stall && is_ret;
  // A redirect in the IR takes priority over a skip request.
  assign do_skip = !stall && ir_valid && skip_req
                && !(is_goto || is_call || is_ret);
  assign bubble  = do_jmp || do_pop || do_skip;

  assign full     = (depth == DW'(STACK_DEPTH));
  assign empty    = (depth == '0);
  assign pop_addr = mem[sp - SPW'(1)];

  always_comb begin
    pc_nxt = pc + 11'd1;
    unique case (1'b1)
      stall:   pc_nxt = pc;
      do_jmp:  pc_nxt = ir_out[10:0];
      do_pop:  pc_nxt = pop_addr;
      default: pc_nxt = pc + 11'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VECTOR;
      ir_out   <= 14'h0000;
      ir_valid <= 1'b0;
      ir_pc    <= 11'h000;
      sp       <= '0;
      depth    <= '0;
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
    end else begin
      stk_ovf <= do_push && full;
      stk_unf <= do_pop && empty;
      if (!stall) begin
        pc    <= pc_nxt;
        ir_pc <= pc;
        if (bubble) begin
          ir_out   <= 14'h0000;
          ir_valid <= 1'b0;
        end else begin
          ir_out   <= Rom_data_in;
          ir_valid <= 1'b1;
        end
      end
      if (do_push) begin
        sp <= sp + SPW'(1);
        if (!full)
          depth <= depth + DW'(1);
      end else if (do_pop) begin
        sp <= sp - SPW'(1);
        if (!empty)
          depth <= depth - DW'(1);
      end
    end
  end

  // Full stack overwrites the oldest entry in place.
  always_ff @(posedge clk) begin
    if (!rst && do_push)
      mem[sp] <= pc;
  end

endmodule
